// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N-to-1 arbitrating multiplexer.
package mux_pkg;

  // Channel selection policies.
  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >>> 1;
    end
    return r;
  endfunction

  // Index width: never narrower than one bit so N=1 still has a select port.
  function automatic int selw(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/mux_arb_n_to_1_rr_arbiter.sv
// Round-robin search: first requesting channel at or after ptr, wrapping modulo N.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter  int N    = 4,
  localparam int SELW = selw(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            grant_vld,
  output logic [SELW-1:0] grant_idx
);

  int cand;

  // Walk the channels starting at ptr; the first request found wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!grant_vld && req[cand]) begin
        grant_vld = 1'b1;
        grant_idx = SELW'(cand);
      end
    end
  end

endmodule

// File: rtl/mux_arb_n_to_1.sv
// N-to-1 multiplexer with a one-deep registered output stage and either a
// fixed (sel-driven) or round-robin channel selection policy.
module mux_arb_n_to_1
  import mux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  parameter  int MODE  = MODE_FIXED,
  localparam int SELW  = selw(N)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_src
);

  logic             load_en;
  logic             grant_vld;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] grant_word;

  logic [WIDTH-1:0] out_data_reg;
  logic             out_valid_reg;
  logic [SELW-1:0]  out_src_reg;

  // The output slot can take a new word when it is empty or being drained;
  // reset blocks any acceptance combinationally.
  assign load_en = (!out_valid_reg || out_ready) && !Reset;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SELW-1:0] ptr_reg;
      logic            arb_vld;
      logic [SELW-1:0] arb_idx;

      rr_arbiter #(.N(N)) u_arb (
        .req       (in_valid),
        .ptr       (ptr_reg),
        .grant_vld (arb_vld),
        .grant_idx (arb_idx)
      );

      // Grant the arbiter's pick when the output slot is free; ready only to the winner.
      always_comb begin
        grant_vld = load_en && arb_vld;
        grant_idx = arb_idx;
        in_ready  = '0;
        for (int i = 0; i < N; i++) begin
          in_ready[i] = grant_vld && (arb_idx == SELW'(i));
        end
      end

      // Pointer moves just past the last granted channel; holds otherwise.
      always_ff @(posedge Clk) begin
        if (Reset) begin
          ptr_reg <= '0;
        end else if (grant_vld) begin
          ptr_reg <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
      end
    end else begin : g_fixed
      // Ready follows sel alone (no cross-channel valid dependency); grant
      // needs the selected channel to be valid, and an out-of-range sel matches nothing.
      always_comb begin
        in_ready  = '0;
        grant_vld = 1'b0;
        grant_idx = sel;
        for (int i = 0; i < N; i++) begin
          if (sel == SELW'(i)) begin
            in_ready[i] = load_en;
            grant_vld   = load_en && in_valid[i];
          end
        end
      end
    end
  endgenerate

  // Pick the granted channel's word out of the flat input bus.
  always_comb begin
    grant_word = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SELW'(i)) begin
        grant_word = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Output register: load on grant, empty on drain without grant, hold on stall.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_data_reg  <= '0;
      out_src_reg   <= '0;
      out_valid_reg <= 1'b0;
    end else if (grant_vld) begin
      out_data_reg  <= grant_word;
      out_src_reg   <= grant_idx;
      out_valid_reg <= 1'b1;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_data  = out_data_reg;
  assign out_src   = out_src_reg;
  assign out_valid = out_valid_reg;

endmodule
